// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage feeding the decoder. Holds the fetch PC, issues
//   16-bit word reads to program memory over a req/ack handshake (at most one
//   read outstanding), buffers returned words in a small prefetch FIFO and
//   presents the FIFO head to the decoder with a valid/ready handshake plus the
//   byte address of each word. A redirect from execute flushes the FIFO and
//   restarts fetch at the new address.
//
// Parameters
//   RESET_PC    fetch address after reset (bit0 ignored)
//   BUF_DEPTH   prefetch FIFO entries, 2 or 4
//
// Ports
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous reset, active-high
//   mem_req      out  1   program memory read request
//   mem_addr     out  16  byte address of requested word (bit0 always 0)
//   mem_ack      in   1   read complete, mem_rdata valid this cycle
//   mem_rdata    in   16  instruction word from memory
//   instr_out    out  16  FIFO head instruction (16'hF000 nop when empty)
//   instr_pc     out  16  byte address of instr_out
//   instr_valid  out  1   FIFO head valid
//   instr_ready  in   1   decoder consumes the head this cycle
//   redirect     in   1   flush FIFO and fetch from redirect_pc
//   redirect_pc  in   16  new fetch address (bit0 forced 0)
//
// Optional build macro FETCH_PBANK_EN adds a program bank register:
//   pb_load      in   1   flush like redirect and load the bank from pb_in
//   pb_in        in   8   new bank value
//   mem_bank     out  8   bank of the requested word, stable with mem_addr
// Without the macro those ports are absent and the bank is implicitly 0.
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instr_out,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
`ifdef FETCH_PBANK_EN
  ,
  input  logic        pb_load,
  input  logic [7:0]  pb_in,
  output logic [7:0]  mem_bank
`endif
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  localparam int                CNT_W     = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(BUF_DEPTH);
  localparam logic [15:0]       NOP_WORD  = 16'hF000;
  localparam logic [15:0]       PC_MASK   = 16'hFFFE;

  // FSM and memory-side registers
  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [15:0] r_fetch_pc;
  logic [15:0] w_fetch_pc_nxt;
  logic        r_mem_req;
  logic        w_mem_req_nxt;
  logic [15:0] r_mem_addr;
  logic        w_issue;
  logic [15:0] w_issue_addr;

  // Prefetch FIFO as a shift register: entry 0 is always the head, so the
  // decoder-facing outputs come straight from registers.
  logic [15:0]          r_data [BUF_DEPTH];
  logic [15:0]          r_pc   [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] r_vld;
  logic [15:0]          w_data_nxt [BUF_DEPTH];
  logic [15:0]          w_pc_nxt   [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] w_vld_nxt;

  // Handshake qualifiers and occupancy bookkeeping
  logic             w_flush;
  logic             w_ack;
  logic             w_pop;
  logic             w_push;
  logic             w_credit;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_cnt_pop;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [15:0]      w_target_pc;
  logic [15:0]      w_seq_pc;

`ifdef FETCH_PBANK_EN
  logic [7:0] r_bank;
  logic [7:0] r_mem_bank;
  // A bank load restarts fetch exactly like a redirect.
  assign w_flush = redirect | pb_load;
`else
  assign w_flush = redirect;
`endif

  // An ack with no request outstanding is not a completion.
  assign w_ack       = r_mem_req & mem_ack;
  assign w_pop       = r_vld[0] & instr_ready;
  // Only data for a live (non-discarded) request is kept; a flush in the
  // same cycle wins over the push.
  assign w_push      = w_ack & (r_state == ST_REQ) & ~w_flush;
  assign w_target_pc = redirect_pc & PC_MASK;
  assign w_seq_pc    = r_fetch_pc + 16'd2;

  // Count valid entries (valid bits are always a contiguous run from entry 0).
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      w_cnt = w_cnt + CNT_W'(r_vld[i]);
    end
  end

  // Occupancy after this cycle's pop and push decides whether a new request
  // may start, so a same-cycle pop frees a slot for the decision.
  assign w_cnt_pop = w_cnt - CNT_W'(w_pop);
  assign w_cnt_nxt = w_flush ? '0 : (w_cnt_pop + CNT_W'(w_push));
  assign w_credit  = ~w_flush & (w_cnt_nxt < DEPTH_CNT);

  // Fetch FSM: request issue, ack handling and redirect/discard sequencing.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_mem_req_nxt  = r_mem_req;
    w_issue        = 1'b0;
    w_issue_addr   = r_fetch_pc;
    case (r_state)
      ST_IDLE: begin
        if (w_flush) begin
          w_fetch_pc_nxt = w_target_pc;
        end else if (w_credit) begin
          w_state_nxt   = ST_REQ;
          w_mem_req_nxt = 1'b1;
          w_issue       = 1'b1;
          w_issue_addr  = r_fetch_pc;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (w_flush) begin
          w_fetch_pc_nxt = w_target_pc;
          if (w_ack) begin
            // Word arrives with the redirect: drop it, refetch next cycle.
            w_state_nxt   = ST_IDLE;
            w_mem_req_nxt = 1'b0;
          end else begin
            // The read cannot be withdrawn; keep it up and drop its data.
            w_state_nxt = ST_DISCARD;
          end
        end else if (w_ack) begin
          w_fetch_pc_nxt = w_seq_pc;
          if (w_credit) begin
            // Back-to-back request keeps mem_req high for full throughput.
            w_issue      = 1'b1;
            w_issue_addr = w_seq_pc;
          end else begin
            w_state_nxt   = ST_IDLE;
            w_mem_req_nxt = 1'b0;
          end
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_DISCARD: begin
        if (w_flush) begin
          w_fetch_pc_nxt = w_target_pc;
        end else begin
          w_fetch_pc_nxt = r_fetch_pc;
        end
        if (w_ack) begin
          w_state_nxt   = ST_IDLE;
          w_mem_req_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_DISCARD;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  // Next FIFO contents: flush clears, pop shifts toward the head, push writes
  // the first free slot after the pop.
  always_comb begin
    for (int i = 0; i < BUF_DEPTH; i++) begin
      w_data_nxt[i] = r_data[i];
      w_pc_nxt[i]   = r_pc[i];
    end
    w_vld_nxt = r_vld;
    if (w_flush) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        w_data_nxt[i] = NOP_WORD;
        w_pc_nxt[i]   = 16'h0000;
      end
      w_vld_nxt = '0;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < BUF_DEPTH - 1; i++) begin
          w_data_nxt[i] = r_data[i+1];
          w_pc_nxt[i]   = r_pc[i+1];
        end
        w_data_nxt[BUF_DEPTH-1] = NOP_WORD;
        w_pc_nxt[BUF_DEPTH-1]   = 16'h0000;
        w_vld_nxt = {1'b0, r_vld[BUF_DEPTH-1:1]};
      end else begin
        w_vld_nxt = r_vld;
      end
      if (w_push) begin
        for (int i = 0; i < BUF_DEPTH; i++) begin
          if (CNT_W'(i) == w_cnt_pop) begin
            w_data_nxt[i] = mem_rdata;
            w_pc_nxt[i]   = r_mem_addr;
            w_vld_nxt[i]  = 1'b1;
          end else begin
            w_vld_nxt[i] = w_vld_nxt[i];
          end
        end
      end else begin
        w_vld_nxt = w_vld_nxt;
      end
    end
  end

  // FSM, fetch PC and memory request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC & PC_MASK;
      r_mem_req  <= 1'b0;
      r_mem_addr <= 16'h0000;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_mem_req  <= w_mem_req_nxt;
      if (w_issue) begin
        r_mem_addr <= w_issue_addr;
      end
    end
  end

  // Prefetch FIFO storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_data[i] <= NOP_WORD;
        r_pc[i]   <= 16'h0000;
      end
      r_vld <= '0;
    end else begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_data[i] <= w_data_nxt[i];
        r_pc[i]   <= w_pc_nxt[i];
      end
      r_vld <= w_vld_nxt;
    end
  end

`ifdef FETCH_PBANK_EN
  // Bank register; the issued bank is captured together with mem_addr so it
  // stays stable for the life of the request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bank     <= 8'h00;
      r_mem_bank <= 8'h00;
    end else begin
      if (pb_load) begin
        r_bank <= pb_in;
      end
      if (w_issue) begin
        r_mem_bank <= r_bank;
      end
    end
  end

  assign mem_bank = r_mem_bank;
`endif

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign instr_out   = r_data[0];
  assign instr_pc    = r_pc[0];
  assign instr_valid = r_vld[0];

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. The bench plays program memory (word
//   content is a salted byte-swap of the address, unique per word) and keeps
//   an abstract model of the instruction stream: the next PC the decoder must
//   see, how many fetched words are buffered, the next address memory must be
//   asked for, and whether the outstanding read is stale after a redirect.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int          DEPTH  = 2;
  localparam logic [15:0] RST_PC = 16'h0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
`ifdef FETCH_PBANK_EN
  logic        pb_load;
  logic [7:0]  pb_in;
  logic [7:0]  mem_bank;
`endif

  int          checks   = 0;
  int          failures = 0;

  // Reference model state
  logic [15:0] salt;
  logic [15:0] exp_pc;      // address the decoder must see next
  logic [15:0] next_fetch;  // address of the next fresh memory request
  int          occ;         // words buffered for the decoder
  logic        disc;        // outstanding read belongs to a flushed stream

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef FETCH_PBANK_EN
    ,
    .pb_load     (pb_load),
    .pb_in       (pb_in),
    .mem_bank    (mem_bank)
`endif
  );

  function automatic logic [15:0] memw(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ salt;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    occ        = 0;
    exp_pc     = RST_PC & 16'hFFFE;
    next_fetch = RST_PC & 16'hFFFE;
    disc       = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, clock, check all outputs.
  task automatic tick(input logic a, input logic rdy, input logic rd, input logic [15:0] rpc);
    logic        pre_req;
    logic [15:0] pre_addr;
    logic        acked;
    logic        flush;
    logic        exp_req;
    logic        new_req;
    mem_ack     = a;
    instr_ready = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    mem_rdata   = memw(mem_addr);
    pre_req     = mem_req;
    pre_addr    = mem_addr;
    flush       = rd;
`ifdef FETCH_PBANK_EN
    flush       = rd | pb_load;
`endif
    acked = pre_req && a;
    if (occ > 0 && rdy) begin
      exp_pc = exp_pc + 16'd2;
      occ    = occ - 1;
    end
    if (flush) begin
      occ        = 0;
      exp_pc     = rpc & 16'hFFFE;
      next_fetch = rpc & 16'hFFFE;
    end else if (acked && !disc) begin
      occ        = occ + 1;
      next_fetch = pre_addr + 16'd2;
    end
    if (pre_req && !a)       exp_req = 1'b1;
    else if (flush)          exp_req = 1'b0;
    else if (acked && disc)  exp_req = 1'b0;
    else                     exp_req = (occ < DEPTH);
    new_req = exp_req && !(pre_req && !a);
    if (flush)      disc = pre_req && !a;
    else if (acked) disc = 1'b0;
    @(posedge clk);
    #1;
    chk("mem_req", {15'd0, mem_req}, {15'd0, exp_req});
    if (exp_req && !new_req) chk("addr_hold", mem_addr, pre_addr);
    if (new_req)             chk("mem_addr", mem_addr, next_fetch);
    chk("instr_valid", {15'd0, instr_valid}, {15'd0, (occ > 0)});
    if (occ > 0) begin
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr_out", instr_out, memw(exp_pc));
    end else begin
      chk("nop_out", instr_out, 16'hF000);
    end
  endtask

  initial begin
    int nv;
    rst         = 1'b1;
    mem_ack     = 1'b0;
    mem_rdata   = 16'h0000;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
`ifdef FETCH_PBANK_EN
    pb_load     = 1'b0;
    pb_in       = 8'h00;
`endif
    salt = 16'($urandom);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {15'd0, mem_req}, 16'd0);
    chk("rst_valid", {15'd0, instr_valid}, 16'd0);
    chk("rst_out", instr_out, 16'hF000);
    chk("rst_pc", instr_pc, 16'h0000);
    rst = 1'b0;
    model_reset();

    // Zero-wait ack, ready=1: addresses step by 2, instr_pc one cycle behind
    tick(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("A_addr0", mem_addr, 16'h0100);
    tick(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("A_addr1", mem_addr, 16'h0102);
    chk("A_pc0", instr_pc, 16'h0100);
    tick(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("A_addr2", mem_addr, 16'h0104);
    chk("A_pc1", instr_pc, 16'h0102);

    // Decoder stalls: exactly DEPTH words buffered, then no request
    repeat (10) tick(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("B_req_off", {15'd0, mem_req}, 16'd0);
    nv = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (instr_valid) nv++;
      tick(1'b0, 1'b1, 1'b0, 16'h0000);
    end
    chk("B_buffered", 16'(nv), 16'(DEPTH));

    // Delayed ack: request held, push only on the ack cycle
    repeat (3) tick(1'b0, 1'b1, 1'b0, 16'h0000);
    chk("C_req_wait", {15'd0, mem_req}, 16'd1);
    chk("C_novalid", {15'd0, instr_valid}, 16'd0);
    tick(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("C_valid", {15'd0, instr_valid}, 16'd1);

    // Redirect to 0x2001 while the read of 0x0104 is pending
    tick(1'b1, 1'b1, 1'b1, 16'h0104);
    tick(1'b0, 1'b1, 1'b0, 16'h0000);
    chk("D_req0104", mem_addr, 16'h0104);
    repeat (2) tick(1'b0, 1'b1, 1'b0, 16'h0000);
    tick(1'b0, 1'b1, 1'b1, 16'h2001);
    chk("D_hold", mem_addr, 16'h0104);
    tick(1'b0, 1'b1, 1'b0, 16'h0000);
    tick(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("D_drop_valid", {15'd0, instr_valid}, 16'd0);
    chk("D_drop_req", {15'd0, mem_req}, 16'd0);
    tick(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("D_new_addr", mem_addr, 16'h2000);
    tick(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("D_first_pc", instr_pc, 16'h2000);

    // PC wrap, then redirect together with ack and pop
    tick(1'b1, 1'b1, 1'b1, 16'hFFFE);
    tick(1'b0, 1'b1, 1'b0, 16'h0000);
    chk("E_addr_fffe", mem_addr, 16'hFFFE);
    tick(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("E_wrap", mem_addr, 16'h0000);
    tick(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("E_pre_valid", {15'd0, instr_valid}, 16'd1);
    tick(1'b1, 1'b1, 1'b1, 16'h3000);
    chk("E_flush_valid", {15'd0, instr_valid}, 16'd0);
    tick(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("E_restart", mem_addr, 16'h3000);

    // Random ack latency, decoder stalls and occasional redirects
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 24) == 0, 16'($urandom));
    end

    // Reset in the middle of a pending request; acks before a new request ignored
    tick(1'b0, 1'b0, 1'b0, 16'h0000);
    tick(1'b0, 1'b0, 1'b0, 16'h0000);
    #2;
    rst     = 1'b1;
    mem_ack = 1'b1;
    #1;
    chk("G_req", {15'd0, mem_req}, 16'd0);
    chk("G_valid", {15'd0, instr_valid}, 16'd0);
    chk("G_nop", instr_out, 16'hF000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (8) tick(1'b1, 1'b1, 1'b0, 16'h0000);

`ifdef FETCH_PBANK_EN
    // Bank load flushes and retargets fetch
    pb_load = 1'b1;
    pb_in   = 8'h03;
    tick(1'b1, 1'b1, 1'b0, 16'h0040);
    pb_load = 1'b0;
    tick(1'b0, 1'b1, 1'b0, 16'h0000);
    chk("H_addr", mem_addr, 16'h0040);
    chk("H_bank", {8'd0, mem_bank}, 16'h0003);
    repeat (4) tick(1'b1, 1'b1, 1'b0, 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
